// File: rtl/strassen_pkg.sv
// Shared types for the Strassen result reader: FSM state and C-matrix element addresses.
package strassen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN
   } state_e;

   localparam logic [1:0] C11_ADDR = 2'd0;
   localparam logic [1:0] C12_ADDR = 2'd1;
   localparam logic [1:0] C21_ADDR = 2'd2;
   localparam logic [1:0] C22_ADDR = 2'd3;

   // Address of the n-th element of a transfer; column-major swaps C12 and C21.
   function automatic logic [1:0] seq_addr(input logic [1:0] n, input logic transpose);
      case (n)
         2'd0:    seq_addr = C11_ADDR;
         2'd1:    seq_addr = transpose ? C21_ADDR : C12_ADDR;
         2'd2:    seq_addr = transpose ? C12_ADDR : C21_ADDR;
         default: seq_addr = C22_ADDR;
      endcase
   endfunction

endpackage

// File: rtl/unload_fifo2.sv
// Two-entry FIFO holding returned result elements (data, matrix index, last flag).
module unload_fifo2 #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [1:0]        push_idx,
   input  logic              push_last,
   input  logic              pop,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        head_idx,
   output logic              head_last,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] data_q [2];
   logic [DATA_W-1:0] data_d [2];
   logic [1:0]        idx_q  [2];
   logic [1:0]        idx_d  [2];
   logic [1:0]        last_q;
   logic [1:0]        last_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      data_d   = data_q;
      idx_d    = idx_q;
      last_d   = last_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         data_d[wr_ptr_q] = push_data;
         idx_d[wr_ptr_q]  = push_idx;
         last_d[wr_ptr_q] = push_last;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // NOTE: the two entries are reset too, so out_data reads 0 while the FIFO is empty after reset.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '{default: '0};
         idx_q    <= '{default: '0};
         last_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         data_q   <= data_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_valid = (count_q != 2'd0);
   assign head_data  = data_q[rd_ptr_q];
   assign head_idx   = idx_q[rd_ptr_q];
   assign head_last  = last_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/strassen_result_reader.sv
// Streams the four C elements out of the result memory with valid/ready handshaking.
// Define STRASSEN_RD_TRANSPOSE_EN for column-major order (C11, C21, C12, C22).
module strassen_result_reader
   import strassen_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              rd_en,
   output logic [1:0]        rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_idx,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

`ifdef STRASSEN_RD_TRANSPOSE_EN
   localparam logic TRANSPOSE = 1'b1;
`else
   localparam logic TRANSPOSE = 1'b0;
`endif

   state_e     state_q, state_d;
   logic [1:0] issue_cnt_q, issue_cnt_d;
   logic       ret_valid_q, ret_valid_d;
   logic [1:0] ret_idx_q, ret_idx_d;
   logic       ret_last_q, ret_last_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic       pop;
   logic [1:0] fifo_count;
   logic [2:0] pending;

   assign pop = out_valid && out_ready;

   // Slots committed after this edge: buffered plus the element arriving now, minus the one leaving.
   assign pending = {1'b0, fifo_count} + {2'b00, ret_valid_q} - {2'b00, pop};
   assign rd_en   = (state_q == ST_READ) && (pending < 3'd2);
   assign rd_addr = seq_addr(issue_cnt_q, TRANSPOSE);

   unload_fifo2 #(.DATA_W(DATA_W)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (ret_valid_q),
      .push_data  (rd_data),
      .push_idx   (ret_idx_q),
      .push_last  (ret_last_q),
      .pop        (pop),
      .head_valid (out_valid),
      .head_data  (out_data),
      .head_idx   (out_idx),
      .head_last  (out_last),
      .count      (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      done_d      = 1'b0;
      ret_valid_d = rd_en;
      ret_idx_d   = rd_addr;
      ret_last_d  = rd_en && (issue_cnt_q == 2'd3);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_READ;
               issue_cnt_d = 2'd0;
            end
         end
         ST_READ: begin
            if (rd_en) begin
               issue_cnt_d = issue_cnt_q + 2'd1;
               if (issue_cnt_q == 2'd3) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && out_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Clearing ret_valid_q on reset drops any read data still returning from an abandoned transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= 2'd0;
         ret_valid_q <= 1'b0;
         ret_idx_q   <= 2'd0;
         ret_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         ret_valid_q <= ret_valid_d;
         ret_idx_q   <= ret_idx_d;
         ret_last_q  <= ret_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_strassen_result_reader.sv
// Self-checking bench for strassen_result_reader against a queue-based model of the expected beats.
module tb_strassen_result_reader;

   localparam int DATA_W = 16;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              rd_en;
   logic [1:0]        rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_idx;
   logic              out_last;
   logic              busy;
   logic              done;

   strassen_result_reader #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [1:0]        idx;
      logic              last;
   } beat_t;

   beat_t             exp_q[$];
   logic [DATA_W-1:0] mem   [4];
   logic [DATA_W-1:0] ref_c [4];
   int                order [4];

   // Result memory with one cycle of read latency.
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int issued, accepted, done_cnt, beats_in_xfer, stall_cnt, start_cyc, ready_mode;
   int first_rd_cyc, first_valid_cyc, first_beat_cyc, last_beat_cyc;
   bit done_seen, prev_stall;

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) check("stall_hold_valid", out_valid, 1);
         if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_valid", out_valid, 0);
            end else begin
               check("out_data", out_data, exp_q[0].data);
               check("out_idx",  out_idx,  exp_q[0].idx);
               check("out_last", out_last, exp_q[0].last);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  accepted++;
                  beats_in_xfer++;
                  if (first_beat_cyc < 0) first_beat_cyc = cyc;
                  last_beat_cyc = cyc;
               end
            end
         end
         if (rd_en) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            check("rd_addr", rd_addr, order[issued % 4]);
            issued++;
            check("outstanding_le2", (issued - accepted) <= 2, 1);
         end
         if (done) begin
            done_cnt++;
            done_seen = 1'b1;
            check("done_after_last", cyc, last_beat_cyc + 1);
            check("busy_low_at_done", busy, 0);
         end
         prev_stall = out_valid && !out_ready;
      end
   end

   // Downstream ready pattern: 0 always, 1 stall 3 cycles at beat 2, 2 toggle, 3 random.
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: begin
            if (beats_in_xfer == 1 && stall_cnt < 3) begin
               out_ready = 1'b0;
               stall_cnt++;
            end else begin
               out_ready = 1'b1;
            end
         end
         2: out_ready = ((cyc - start_cyc) % 2 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic load_and_expect(input bit rnd);
      beat_t b;
      for (int k = 0; k < 4; k++) mem[k] = rnd ? DATA_W'($urandom) : ref_c[k];
      for (int k = 0; k < 4; k++) begin
         b.data = mem[order[k]];
         b.idx  = 2'(order[k]);
         b.last = (k == 3);
         exp_q.push_back(b);
      end
      beats_in_xfer   = 0;
      stall_cnt       = 0;
      done_seen       = 1'b0;
      first_rd_cyc    = -1;
      first_valid_cyc = -1;
      first_beat_cyc  = -1;
      last_beat_cyc   = -1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done_seen; i++) begin
         @(negedge clk);
         #1;
      end
      check("done_within_budget", done_seen, 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rd_en"},     rd_en,     0);
      check({tag, "_rd_addr"},   rd_addr,   0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"},  out_data,  0);
      check({tag, "_out_idx"},   out_idx,   0);
      check({tag, "_out_last"},  out_last,  0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_done"},      done,      0);
   endtask

   initial begin
      int d0;
`ifdef STRASSEN_RD_TRANSPOSE_EN
      order = '{0, 2, 1, 3};
`else
      order = '{0, 1, 2, 3};
`endif
      ref_c = '{16'd19, 16'd22, 16'd43, 16'd50};
      mem   = ref_c;
      rst_n = 1'b0;
      start = 1'b0;
      out_ready  = 1'b1;
      ready_mode = 0;
      issued = 0; accepted = 0; done_cnt = 0; start_cyc = 0;
      prev_stall = 1'b0;
      load_and_expect(0);
      exp_q.delete();

      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed transfer, ready held high.
      load_and_expect(0);
      @(negedge clk);
      pulse_start();
      check("busy_after_start", busy, 1);
      wait_done(40);
      check("first_rd_cycle",    first_rd_cyc,    start_cyc);
      check("first_valid_cycle", first_valid_cyc, start_cyc + 2);
      check("beats_consecutive", last_beat_cyc - first_beat_cyc, 3);
      check("beats_full",        beats_in_xfer, 4);

      // Three-cycle stall on the second element.
      ready_mode = 1;
      load_and_expect(0);
      @(negedge clk);
      pulse_start();
      wait_done(40);
      check("stall_beats",  beats_in_xfer, 4);
      check("stall_span",   last_beat_cyc - first_beat_cyc, 6);

      // start repeated while busy is ignored.
      ready_mode = 0;
      d0 = done_cnt;
      load_and_expect(0);
      @(negedge clk);
      pulse_start();
      repeat (1) @(negedge clk);
      pulse_start();
      wait_done(40);
      repeat (6) @(negedge clk);
      check("restart_beats",     beats_in_xfer, 4);
      check("restart_one_done",  done_cnt - d0, 1);
      check("restart_queue_empty", exp_q.size(), 0);
      check("restart_idle_busy", busy, 0);

      // start in the done cycle is accepted.
      load_and_expect(1);
      @(negedge clk);
      pulse_start();
      wait_done(40);
      load_and_expect(1);
      pulse_start();
      wait_done(40);
      check("chain_first_rd", first_rd_cyc, start_cyc);
      check("chain_beats",    beats_in_xfer, 4);

      // Toggling ready: one beat every other cycle.
      ready_mode = 2;
      load_and_expect(1);
      @(negedge clk);
      pulse_start();
      wait_done(40);
      check("toggle_beats", beats_in_xfer, 4);
      check("toggle_span",  last_beat_cyc - first_beat_cyc, 6);

      // Reset after the second handshake abandons the transfer.
      ready_mode = 0;
      load_and_expect(0);
      @(negedge clk);
      pulse_start();
      for (int i = 0; i < 40 && beats_in_xfer < 2; i++) begin
         @(negedge clk);
         #1;
      end
      check("reached_two_beats", beats_in_xfer, 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      exp_q.delete();
      issued = 0;
      accepted = 0;
      prev_stall = 1'b0;
      #2;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy",  busy, 0);
      load_and_expect(0);
      pulse_start();
      wait_done(40);
      check("post_rst_beats", beats_in_xfer, 4);

      // Random data with random back-pressure.
      ready_mode = 3;
      for (int t = 0; t < 6; t++) begin
         load_and_expect(1);
         @(negedge clk);
         pulse_start();
         wait_done(100);
         check("rand_beats", beats_in_xfer, 4);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
